// File: rtl/tinycpu_pkg.sv
// Shared Tiny CPU definitions: opcode width, HALT word, sequencer states and decoder opcodes.
package tinycpu_pkg;

  localparam int OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_e;

  // Opcodes understood by the instruction decoder; 4'hF is reserved for HALT.
  localparam logic [OPCODE_W-1:0] OP_NOP = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_CLR = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_LDA = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_LDB = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_XOR = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_NOT = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_SHL = 4'd10;
  localparam logic [OPCODE_W-1:0] OP_SHR = 4'd11;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'd12;

endpackage

// File: rtl/seq_program_mem.sv
// Program store for the sequencer: DEPTH x 4-bit words, one write port, combinational read.
module seq_program_mem
  import tinycpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [OPCODE_W-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [OPCODE_W-1:0] rdata
);

  // Deliberately not reset: the program must survive a reset.
  logic [OPCODE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// Issues stored opcodes to the decoder over valid/ready until HALT, end of program or stop.
// Define TINYCPU_SEQ_LOOP_EN to wrap from the last word back to address 0 instead of halting.
module instruction_sequencer
  import tinycpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [OPCODE_W-1:0] wr_data,
  input  logic                start,
  input  logic                stop,
  input  logic                instr_ready,
  output logic [OPCODE_W-1:0] instruction,
  output logic                instr_valid,
  output logic [AW-1:0]       pc,
  output logic                busy,
  output logic                halted
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  seq_state_e          state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d, pc_next;
  logic [OPCODE_W-1:0] instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                busy_q, halted_q;
  logic [AW-1:0]       rd_addr;
  logic [OPCODE_W-1:0] rd_data;
  logic                end_halt;

  // Writes are only allowed while nothing is being fetched.
  seq_program_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_en && (state_q != RUN)),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign pc_next = (pc_q == LAST_ADDR) ? '0 : pc_q + AW'(1);

`ifdef TINYCPU_SEQ_LOOP_EN
  assign end_halt = 1'b0;
`else
  assign end_halt = (pc_q == LAST_ADDR);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    rd_addr = '0;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (!valid_q) begin
          // First RUN cycle: fetch address 0.
          if (rd_data == HALT_OPCODE) begin
            state_d = HALTED;
          end else begin
            instr_d = rd_data;
            valid_d = 1'b1;
          end
        end else if (instr_ready) begin
          rd_addr = pc_next;
          if (end_halt || (rd_data == HALT_OPCODE)) begin
            state_d = HALTED;
            valid_d = 1'b0;
          end else begin
            pc_d    = pc_next;
            instr_d = rd_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
      valid_d = 1'b0;
      pc_d    = '0;
      instr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      busy_q   <= (state_d == RUN);
      halted_q <= (state_d == HALTED);
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed vector table, full-depth run and randomized programs.
module tb_instruction_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int MAXN  = 40;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          start;
  logic          stop;
  logic          instr_ready;
  logic [3:0]    instruction;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_sequencer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .stop        (stop),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       we;
    logic [3:0] wa;
    logic [3:0] wd;
    logic       st;
    logic       sp;
    logic       rdy;
    logic       chk_instr;
    logic [3:0] e_instr;
    logic       e_valid;
    logic [3:0] e_pc;
    logic       e_busy;
    logic       e_halted;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic we, input logic [3:0] wa, input logic [3:0] wd,
                     input logic st, input logic sp, input logic rdy, input logic ci,
                     input logic [3:0] ei, input logic ev, input logic [3:0] ep,
                     input logic eb, input logic eh);
    vec_t v;
    v = '{rst, we, wa, wd, st, sp, rdy, ci, ei, ev, ep, eb, eh};
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    reset = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    start = 0; stop = 0; instr_ready = 0;
  endtask

  // Reference model: the opcodes a program issues, walked straight from the storage rules.
  logic [3:0] mdl_mem [DEPTH];

  task automatic model_trace(output int exp_q[$], output bit trunc);
    int a;
    exp_q = {};
    trunc = 0;
    a = 0;
    forever begin
      if (mdl_mem[a] == 4'hF) break;
      exp_q.push_back(int'(mdl_mem[a]));
      if (exp_q.size() >= MAXN) begin trunc = 1; break; end
      if (a == DEPTH - 1) begin
`ifdef TINYCPU_SEQ_LOOP_EN
        a = 0;
`else
        break;
`endif
      end else begin
        a++;
      end
    end
  endtask

  initial begin
    int   exp_q[$];
    int   got_q[$];
    bit   trunc;
    logic v, r;
    logic [3:0] ins, p;
    bit   done;

    idle_inputs();
    reset = 1;
    step();
    chk("rst_instr", instruction, 0); chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 0); chk("rst_busy", busy, 0); chk("rst_halted", halted, 0);
    reset = 0;

    //  rst we wa wd st sp rdy ci  instr v pc  b  h
    add(0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 2, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3, 4'hF, 1, 0, 1, 0, 0, 0, 0, 1, 0);   // write + start together
    add(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 3, 1, 2, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 1);      // HALT reached
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);      // restart from HALTED
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 1, 0);      // backpressure x3
    add(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 3, 1, 2, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 2, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);      // stop while valid
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0);
    add(0, 1, 1, 7, 0, 0, 0, 1, 1, 1, 0, 1, 0);      // write during RUN
    add(0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 1, 1, 0);
    add(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);      // mid-run reset
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);      // start + stop
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 3, 1, 2, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 1);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      start = vecs[i].st; stop = vecs[i].sp; instr_ready = vecs[i].rdy;
      step();
      if (vecs[i].chk_instr) chk($sformatf("v%0d_instr", i), instruction, vecs[i].e_instr);
      chk($sformatf("v%0d_valid", i), instr_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_halted", i), halted, vecs[i].e_halted);
      $display("vec %0d: instr=%0h valid=%0b pc=%0d busy=%0b halted=%0b",
               i, instruction, instr_valid, pc, busy, halted);
    end
    idle_inputs();

    // Full-depth program of 5s, loaded from HALTED.
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1; wr_addr = AW'(a); wr_data = 4'd5;
      mdl_mem[a] = 4'd5;
      step();
    end
    wr_en = 0; start = 1; step(); start = 0; instr_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk($sformatf("fill_pc%0d", i), pc, i);
      chk($sformatf("fill_valid%0d", i), instr_valid, 1);
      chk($sformatf("fill_instr%0d", i), instruction, 5);
    end
    step();
`ifdef TINYCPU_SEQ_LOOP_EN
    chk("fill_wrap_valid", instr_valid, 1);
    chk("fill_wrap_pc", pc, 0);
    chk("fill_wrap_instr", instruction, 5);
`else
    chk("fill_end_valid", instr_valid, 0);
    chk("fill_end_halted", halted, 1);
    chk("fill_end_pc", pc, DEPTH - 1);
`endif
    $display("fill run: valid=%0b pc=%0d halted=%0b", instr_valid, pc, halted);
    instr_ready = 0; stop = 1; step(); stop = 0;
    chk("fill_stop_busy", busy, 0);

    // Randomized programs with random backpressure and ignored RUN-time writes.
    for (int it = 0; it < 30; it++) begin
      for (int a = 0; a < DEPTH; a++) begin
        mdl_mem[a] = ($urandom_range(0, 6) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        wr_en = 1; wr_addr = AW'(a); wr_data = mdl_mem[a];
        step();
      end
      wr_en = 0;
      model_trace(exp_q, trunc);
      got_q = {};
      start = 1; step(); start = 0;
      done = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        if (halted || got_q.size() >= MAXN) begin done = 1; break; end
        v = instr_valid; ins = instruction; p = pc;
        r = ($urandom_range(0, 2) != 0);
        instr_ready = r;
        wr_en = ($urandom_range(0, 3) == 0);
        wr_addr = AW'($urandom_range(0, DEPTH - 1));
        wr_data = 4'($urandom_range(0, 15));
        step();
        chk("rand_excl", int'(busy & halted), 0);
        if (v && r) got_q.push_back(int'(ins));
        else if (v) begin
          chk("rand_hold_valid", instr_valid, 1);
          chk("rand_hold_instr", instruction, ins);
          chk("rand_hold_pc", pc, p);
        end
      end
      wr_en = 0; instr_ready = 0;
      chk("rand_timeout", int'(done), 1);
      chk("rand_count", got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
        chk($sformatf("rand_op%0d", k), got_q[k], exp_q[k]);
      if (!trunc) chk("rand_halted", halted, 1);
      else chk("rand_busy", busy, 1);
      $display("rand %0d: issued=%0d expected=%0d halted=%0b", it, got_q.size(), exp_q.size(), halted);
      stop = 1; step(); stop = 0;
      chk("rand_stop_valid", instr_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
